// File: rtl/hamming16t11d_enc_stream.sv
// ============================================================================
// Module   : hamming16t11d_enc_stream
// Brief    : Streaming 11->16 bit SECDED encoder with a 2-entry output buffer,
//            armed XOR fault injection and a saturating accepted-word counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hamming16t11d_enc_stream #(
  parameter int COUNTW = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [10:0]       data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [15:0]       hv_o,
  output logic              valid_o,
  input  logic              ready_i,
  input  logic              inj_req_i,
  input  logic [15:0]       inj_mask_i,
  output logic              inj_armed_o,
  output logic              inj_done_o,
  output logic [COUNTW-1:0] cnt_o
);

  typedef enum logic [0:0] {
    INJ_IDLE  = 1'b0,
    INJ_ARMED = 1'b1
  } inj_state_t;

  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] c;
    c     = '0;
    c[3]  = d[0];
    c[5]  = d[1];
    c[6]  = d[2];
    c[7]  = d[3];
    c[9]  = d[4];
    c[10] = d[5];
    c[11] = d[6];
    c[12] = d[7];
    c[13] = d[8];
    c[14] = d[9];
    c[15] = d[10];
    c[1]  = c[3] ^ c[5] ^ c[7] ^ c[9] ^ c[11] ^ c[13] ^ c[15];
    c[2]  = c[3] ^ c[6] ^ c[7] ^ c[10] ^ c[11] ^ c[14] ^ c[15];
    c[4]  = c[5] ^ c[6] ^ c[7] ^ c[12] ^ c[13] ^ c[14] ^ c[15];
    c[8]  = ^c[15:9];
    c[0]  = ^c[15:1];
    return c;
  endfunction

  logic [1:0][15:0]  mem_q, mem_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        occ_q, occ_d;
  inj_state_t        state_q, state_d;
  logic [15:0]       mask_q, mask_d;
  logic              done_q, done_d;
  logic [COUNTW-1:0] cnt_q, cnt_d;

  logic push, pop;

  // ready_o depends only on stored occupancy and reset, never on ready_i.
  assign ready_o     = (occ_q != 2'd2) & ~rst_i;
  assign valid_o     = (occ_q != 2'd0);
  assign hv_o        = mem_q[rd_ptr_q];
  assign inj_armed_o = (state_q == INJ_ARMED);
  assign inj_done_o  = done_q;
  assign cnt_o       = cnt_q;

  assign push = valid_i & ready_o;
  assign pop  = valid_o & ready_i;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    state_d  = state_q;
    mask_d   = mask_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;

    if (push) begin
      mem_d[wr_ptr_q] = encode(data_i) ^ ((state_q == INJ_ARMED) ? mask_q : 16'h0000);
      wr_ptr_d        = ~wr_ptr_q;
      if (cnt_q != {COUNTW{1'b1}}) begin
        cnt_d = cnt_q + COUNTW'(1);
      end
      if (state_q == INJ_ARMED) begin
        done_d  = 1'b1;
        state_d = INJ_IDLE;
      end
    end

    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase

    // A request in the consuming cycle re-arms with the new mask after the
    // old mask has been applied above.
    if (inj_req_i) begin
      state_d = INJ_ARMED;
      mask_d  = inj_mask_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q    <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
      state_q  <= INJ_IDLE;
      mask_q   <= 16'h0000;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      state_q  <= state_d;
      mask_q   <= mask_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hamming16t11d_enc_stream.sv
// ============================================================================
// Module   : tb_hamming16t11d_enc_stream
// Brief    : Self-checking bench: directed steps plus a randomized stream
//            scored against a positional Hamming reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hamming16t11d_enc_stream;

  localparam int CW     = 4;
  localparam int CNTMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_i, valid_i, ready_i, inj_req_i;
  logic [10:0]   data_i;
  logic [15:0]   inj_mask_i;
  logic          ready_o, valid_o, inj_armed_o, inj_done_o;
  logic [15:0]   hv_o;
  logic [CW-1:0] cnt_o;

  hamming16t11d_enc_stream #(.COUNTW(CW)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .hv_o       (hv_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .inj_req_i  (inj_req_i),
    .inj_mask_i (inj_mask_i),
    .inj_armed_o(inj_armed_o),
    .inj_done_o (inj_done_o),
    .cnt_o      (cnt_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [15:0] exp_q[$];
  logic [10:0] dat_q[$];
  logic [15:0] msk_q[$];
  logic [15:0] popped[$];
  logic        m_armed = 1'b0;
  logic [15:0] m_mask  = '0;
  logic        m_done  = 1'b0;
  int          m_cnt   = 0;
  int          n_acc   = 0;

  int pos[11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

  function automatic logic [15:0] ref_enc(input logic [10:0] d);
    logic [15:0] c;
    c = '0;
    for (int k = 0; k < 11; k++) c[pos[k]] = d[k];
    for (int p = 1; p < 16; p = p * 2) begin
      logic b;
      b = 1'b0;
      for (int i = 1; i < 16; i++)
        if (((i & p) != 0) && (i != p)) b = b ^ c[i];
      c[p] = b;
    end
    c[0] = ^c[15:1];
    return c;
  endfunction

  // Returns {status, data}: status 0 clean, 1 single corrected, 2 double.
  function automatic logic [12:0] ref_dec(input logic [15:0] cw);
    int          syn;
    logic        par;
    logic [15:0] c;
    logic [10:0] d;
    logic [1:0]  st;
    c   = cw;
    syn = 0;
    for (int i = 1; i < 16; i++) if (c[i]) syn = syn ^ i;
    par = ^c;
    st  = 2'd0;
    if (par) begin
      st = 2'd1;
      if (syn != 0) c[syn] = ~c[syn];
    end else if (syn != 0) begin
      st = 2'd2;
    end
    for (int k = 0; k < 11; k++) d[k] = c[pos[k]];
    return {st, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    logic        m_ready, push, pop;
    logic [15:0] obs, msk;
    logic [12:0] dec;
    #1;
    m_ready = (exp_q.size() != 2) && !rst_i;
    chk("ready_o", ready_o, m_ready);
    push = valid_i && m_ready;
    pop  = (exp_q.size() != 0) && ready_i;
    if (rst_i) begin
      exp_q.delete(); dat_q.delete(); msk_q.delete();
      m_armed = 1'b0; m_mask = '0; m_done = 1'b0; m_cnt = 0;
    end else begin
      if (pop) begin
        obs = hv_o;
        popped.push_back(obs);
        chk("pop_order", obs, exp_q[0]);
        if (msk_q[0] == 16'h0000) chk("pop_parity", ^obs, 1'b0);
        if ($countones(msk_q[0]) <= 1) begin
          dec = ref_dec(obs);
          chk("pop_decode", dec[10:0], dat_q[0]);
        end
        void'(exp_q.pop_front()); void'(dat_q.pop_front()); void'(msk_q.pop_front());
      end
      m_done = 1'b0;
      if (push) begin
        msk = m_armed ? m_mask : 16'h0000;
        exp_q.push_back(ref_enc(data_i) ^ msk);
        dat_q.push_back(data_i);
        msk_q.push_back(msk);
        m_done = m_armed;
        m_armed = 1'b0;
        if (m_cnt < CNTMAX) m_cnt++;
        n_acc++;
      end
      if (inj_req_i) begin
        m_armed = 1'b1;
        m_mask  = inj_mask_i;
      end
    end
    @(posedge clk);
    #1;
    chk("valid_o", valid_o, exp_q.size() != 0);
    if (exp_q.size() != 0) chk("hv_o_head", hv_o, exp_q[0]);
    chk("inj_armed_o", inj_armed_o, m_armed);
    chk("inj_done_o", inj_done_o, m_done);
    chk("cnt_o", cnt_o, m_cnt);
  endtask

  logic [15:0] enc_in[4]  = '{16'h0000, 16'h0001, 16'h0400, 16'h07FF};
  logic [15:0] enc_out[4] = '{16'h0000, 16'h000F, 16'h8117, 16'hFFFF};
  logic [12:0] dres;
  int          cyc;
  int          acc0;

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; data_i = '0;
    inj_req_i = 1'b0; inj_mask_i = '0;

    // Reset state
    tick(); tick();
    chk("rst_hv_o", hv_o, 16'h0000);
    chk("rst_valid_o", valid_o, 1'b0);
    rst_i = 1'b0;

    // Encoding values with ready_i high
    for (int k = 0; k < 4; k++) begin
      valid_i = 1'b1; data_i = enc_in[k][10:0];
      tick();
      chk("enc_value", hv_o, enc_out[k]);
      chk("enc_valid", valid_o, 1'b1);
    end
    valid_i = 1'b0;
    tick(); tick();

    // Backpressure: only two words fit while ready_i is low
    popped.delete();
    ready_i = 1'b0; valid_i = 1'b1;
    data_i = 11'h001; tick();
    data_i = 11'h400; tick();
    data_i = 11'h7FF; tick();
    chk("bp_ready_low", ready_o, 1'b0);
    tick();
    chk("bp_head_stable", hv_o, 16'h000F);
    ready_i = 1'b1;
    tick(); tick();
    valid_i = 1'b0;
    tick(); tick(); tick();
    chk("bp_npop", popped.size(), 3);
    if (popped.size() == 3) begin
      chk("bp_out0", popped[0], 16'h000F);
      chk("bp_out1", popped[1], 16'h8117);
      chk("bp_out2", popped[2], 16'hFFFF);
    end

    // Single-bit injection, then a clean word
    inj_req_i = 1'b1; inj_mask_i = 16'h0008; tick();
    inj_req_i = 1'b0;
    chk("inj_armed", inj_armed_o, 1'b1);
    valid_i = 1'b1; data_i = 11'h001; tick();
    chk("inj_value", hv_o, 16'h0007);
    chk("inj_done_pulse", inj_done_o, 1'b1);
    tick();
    chk("clean_after_inj", hv_o, 16'h000F);
    chk("inj_done_once", inj_done_o, 1'b0);
    valid_i = 1'b0; tick();

    // Double-bit mask flagged by the decoder
    inj_req_i = 1'b1; inj_mask_i = 16'h0006; tick();
    inj_req_i = 1'b0; valid_i = 1'b1; tick();
    valid_i = 1'b0;
    dres = ref_dec(hv_o);
    chk("dbl_value", hv_o, 16'h0009);
    chk("dbl_flag", dres[12:11], 2'd2);
    tick();

    // Request coinciding with the consuming transfer re-arms with the new mask
    inj_req_i = 1'b1; inj_mask_i = 16'h0001; tick();
    inj_mask_i = 16'h0002; valid_i = 1'b1; tick();
    inj_req_i = 1'b0;
    chk("rearm_old_mask", hv_o, 16'h000E);
    chk("rearm_armed", inj_armed_o, 1'b1);
    tick();
    chk("rearm_new_mask", hv_o, 16'h000D);
    valid_i = 1'b0; tick(); tick();

    // Counter saturation from a fresh reset
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    valid_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      data_i = 11'($urandom_range(0, 2047));
      tick();
    end
    valid_i = 1'b0; tick();
    chk("cnt_saturated", cnt_o, CNTMAX);

    // Reset mid-stream with two buffered words and injection armed
    ready_i = 1'b0; valid_i = 1'b1;
    data_i = 11'h123; tick();
    data_i = 11'h456; tick();
    valid_i = 1'b0; inj_req_i = 1'b1; inj_mask_i = 16'h0100; tick();
    inj_req_i = 1'b0;
    rst_i = 1'b1; #1;
    chk("midrst_ready_low", ready_o, 1'b0);
    tick();
    chk("midrst_valid", valid_o, 1'b0);
    chk("midrst_armed", inj_armed_o, 1'b0);
    chk("midrst_cnt", cnt_o, 0);
    rst_i = 1'b0; ready_i = 1'b1;

    // Random streaming against the scoreboard
    acc0 = n_acc;
    cyc  = 0;
    while ((n_acc - acc0) < 10000 && cyc < 60000) begin
      valid_i    = ($urandom_range(0, 9) < 7);
      ready_i    = ($urandom_range(0, 9) < 7);
      data_i     = 11'($urandom_range(0, 2047));
      inj_req_i  = ($urandom_range(0, 49) == 0);
      inj_mask_i = 16'(1) << $urandom_range(0, 15);
      tick();
      cyc++;
    end
    chk("rand_words_done", ((n_acc - acc0) >= 10000), 1'b1);
    valid_i = 1'b0; ready_i = 1'b1; inj_req_i = 1'b0;
    tick(); tick(); tick();
    chk("drained", valid_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hamming16t11d_enc_stream.md
# hamming16t11d_enc_stream

Streaming SECDED encoder that converts 11-bit data words into 16-bit extended-Hamming codewords. Codewords are bit-exact with the team's `hamming16t11d` layout, so any 16-bit decoder of that scheme corrects single errors and flags double errors. The block sits on the write side of protected storage and channels in the SEU IP, using valid/ready handshakes on both sides. It holds a 2-entry output buffer and has an armed fault-injection path for exercising downstream decoders.

## Interface
- `COUNTW`, default 16: width of the saturating encoded-word counter.
- `clk_i`, in, 1: clock. All logic is on the rising edge.
- `rst_i`, in, 1: reset. One clock domain; reset is synchronous and active-high.
- `data_i`, in, 11: data word to encode.
- `valid_i`, in, 1: `data_i` is valid.
- `ready_o`, out, 1: the block can accept a word this cycle.
- `hv_o`, out, 16: codeword at the buffer head.
- `valid_o`, out, 1: `hv_o` is valid.
- `ready_i`, in, 1: the downstream side accepts `hv_o`.
- `inj_req_i`, in, 1: one-cycle pulse that arms fault injection.
- `inj_mask_i`, in, 16: XOR mask, captured when `inj_req_i` is high.
- `inj_armed_o`, out, 1: injection is armed and pending.
- `inj_done_o`, out, 1: one-cycle pulse when the mask is applied.
- `cnt_o`, out, COUNTW: number of accepted words, saturating.

## Operation
- **Codeword layout**
  - `hv[3,5,6,7,9,10,11,12,13,14,15]` = `data_i[0..10]`, in that order.
  - `hv[1]` = XOR of positions {3,5,7,9,11,13,15}.
  - `hv[2]` = XOR of {3,6,7,10,11,14,15}.
  - `hv[4]` = XOR of {5,6,7,12,13,14,15}.
  - `hv[8]` = XOR of {9..15}.
  - `hv[0]` = XOR of `hv[15:1]`, so XOR of all 16 bits is 0 (even overall parity).
- **Input transfer:** happens when `valid_i & ready_o`. The word is encoded and the codeword is written into a 2-entry FIFO.
- **Output transfer:** happens when `valid_o & ready_i`. The head entry is popped.
- **Flow control**
  - `ready_o` = (occupancy != 2) & ~`rst_i`.
  - `valid_o` = (occupancy != 0).
  - `hv_o` is the head entry and must be stable while `valid_o & ~ready_i`.
- **Simultaneous push and pop:** occupancy stays the same. At occupancy 1 this gives one word per cycle.
- **Injection state machine**
  - IDLE → ARMED on `inj_req_i`; `inj_mask_i` is captured.
  - In ARMED, on the next input transfer the stored codeword is `encode(data_i) ^ mask`. `inj_done_o` pulses the following cycle and the state returns to IDLE.
  - `inj_req_i` while ARMED and without a transfer re-captures the mask and the state stays ARMED.
  - `inj_req_i` in the same cycle as the consuming transfer: the old mask is applied and the state ends ARMED holding the new mask.
  - `inj_armed_o` = (state == ARMED).
- **Counter:** `cnt_o` increments by 1 on each input transfer and saturates at 2^COUNTW−1 with no wrap. Injected words are counted.

## Timing
- **Reset values:**
  - Outputs: `valid_o`=0, `hv_o`=0, `inj_armed_o`=0, `inj_done_o`=0, `cnt_o`=0.
  - Occupancy is 0 and the injection state is IDLE.
- **Reset and `ready_o`:** `ready_o` is 0 in any cycle `rst_i` is high, and 1 in the first cycle after release.
- **Reset mid-operation:** buffered codewords and any armed injection are discarded. The counter clears.
- **Latency:** 1 cycle. A word accepted on edge N is presented with `valid_o`=1 in cycle N+1.
- **Throughput:** one word per cycle while `ready_i` is held high.
- **Backpressure:**
  - With `ready_i`=0, two words are accepted. `ready_o` falls in the cycle after the second acceptance.
  - `ready_o` returns to 1 the cycle after a pop.
  - There is no combinational path from `ready_i` to `ready_o`.
- **Order:** strict FIFO. No word is dropped or duplicated.
- **Injection timing:**
  - The mask is first usable by a transfer in the cycle after `inj_req_i`.
  - `inj_done_o` asserts in the same cycle as `valid_o` for the injected word, when occupancy was 0.

## Test plan
- **Encoding values** (`ready_i`=1): data 0x000→0x0000, 0x001→0x000F, 0x400→0x8117, 0x7FF→0xFFFF. Each appears one cycle after acceptance.
- **Backpressure:** hold `ready_i`=0 and drive 0x001, 0x400, 0x7FF.
  - Only the first two are accepted and `ready_o` drops.
  - Release `ready_i`: outputs are 0x000F, 0x8117, 0xFFFF in order, and the third word is accepted once space frees.
- **Injection:** pulse `inj_req_i` with mask 0x0008, then send 0x001.
  - `hv_o` = 0x0007 and `inj_done_o` pulses once.
  - The next word 0x001 gives 0x000F.
  - A double-bit mask 0x0006 gives a word the decoder flags as a double error.
- **Random streaming:** random `valid_i`/`ready_i` over 10k words.
  - A scoreboard checks order, checks zero overall parity for all non-injected words, and checks that SECDED decode returns the original data.
- **Counter:** with COUNTW=4, accept 20 words; `cnt_o` ends at 15.
- **Reset mid-stream:** assert `rst_i` with 2 words buffered and injection armed.
  - The next cycle shows `valid_o`=0, `inj_armed_o`=0, `cnt_o`=0, and `ready_o`=0 while reset is held.
